// File: rtl/pixel_window_feeder.sv
// Raster-to-window front end: buffers the previous row and emits 2x4 T/B pixel windows.
// Optional macro ISP_WIN_COORD_EN adds win_x/win_y window coordinate outputs.
module pixel_window_feeder #(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64,
  parameter int unsigned COL_W      = $clog2(IMG_WIDTH),
  parameter int unsigned ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic [7:0]       T1,
  output logic [7:0]       T2,
  output logic [7:0]       T3,
  output logic [7:0]       T4,
  output logic [7:0]       B1,
  output logic [7:0]       B2,
  output logic [7:0]       B3,
  output logic [7:0]       B4,
  output logic             win_valid,
  output logic             frame_done
`ifdef ISP_WIN_COORD_EN
  ,
  output logic [COL_W-1:0] win_x,
  output logic [ROW_W-1:0] win_y
`endif
);

  typedef enum logic [1:0] {IDLE, FIRST_ROW, STREAM} state_e;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(3);

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [2:0][7:0]       t_hist_q, t_hist_d;
  logic [2:0][7:0]       b_hist_q, b_hist_d;
  logic [3:0][7:0]       t_out_q, t_out_d;
  logic [3:0][7:0]       b_out_q, b_out_d;
  logic                  win_valid_q, win_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [7:0]            line_buf_q [IMG_WIDTH];
  logic [7:0]            line_buf_d [IMG_WIDTH];
`ifdef ISP_WIN_COORD_EN
  logic [COL_W-1:0]      win_x_q, win_x_d;
  logic [ROW_W-1:0]      win_y_q, win_y_d;
`endif

  logic                  accept;
  logic                  start;
  logic [COL_W-1:0]      wcol;
  logic [7:0]            rd;
  logic [3:0][7:0]       t_win;
  logic [3:0][7:0]       b_win;

  assign pix_ready = !rst;
  assign accept    = pix_valid && pix_ready;

  // Next-state, line buffer update and window assembly; index 0 is the oldest column.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    t_hist_d     = t_hist_q;
    b_hist_d     = b_hist_q;
    t_out_d      = t_out_q;
    b_out_d      = b_out_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    line_buf_d   = line_buf_q;
`ifdef ISP_WIN_COORD_EN
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
`endif

    start = accept && pix_sof;
    wcol  = start ? '0 : col_q;
    rd    = line_buf_q[wcol];
    // History is dropped at column 0 so windows never straddle rows.
    t_win = (wcol == '0) ? {rd, 24'h0}     : {rd, t_hist_q};
    b_win = (wcol == '0) ? {pix_in, 24'h0} : {pix_in, b_hist_q};

    if (accept && (start || state_q != IDLE)) begin
      line_buf_d[wcol] = pix_in;
      t_hist_d         = t_win[3:1];
      b_hist_d         = b_win[3:1];
    end

    if (start) begin
      state_d = FIRST_ROW;
      col_d   = COL_W'(1);
      row_d   = '0;
    end else if (accept) begin
      case (state_q)
        FIRST_ROW: begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = ROW_W'(1);
            state_d = STREAM;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        STREAM: begin
          if (col_q >= COL_WIN) begin
            win_valid_d = 1'b1;
            t_out_d     = t_win;
            b_out_d     = b_win;
`ifdef ISP_WIN_COORD_EN
            win_x_d     = col_q;
            win_y_d     = row_q;
`else
            // coordinates not tracked in this build
`endif
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              frame_done_d = 1'b1;
              row_d        = '0;
              state_d      = IDLE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      t_hist_q     <= '0;
      b_hist_q     <= '0;
      t_out_q      <= '0;
      b_out_q      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef ISP_WIN_COORD_EN
      win_x_q      <= '0;
      win_y_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      t_hist_q     <= t_hist_d;
      b_hist_q     <= b_hist_d;
      t_out_q      <= t_out_d;
      b_out_q      <= b_out_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
`ifdef ISP_WIN_COORD_EN
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
`endif
    end
  end

  // Line buffer holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
  end

  assign T1         = t_out_q[0];
  assign T2         = t_out_q[1];
  assign T3         = t_out_q[2];
  assign T4         = t_out_q[3];
  assign B1         = b_out_q[0];
  assign B2         = b_out_q[1];
  assign B3         = b_out_q[2];
  assign B4         = b_out_q[3];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
`ifdef ISP_WIN_COORD_EN
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
`endif

endmodule

// File: tb/tb_pixel_window_feeder.sv
// Directed/randomized bench for pixel_window_feeder with a frame-image reference model.
module tb_pixel_window_feeder;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = 8'h00;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       pix_ready;
  logic [7:0] T1, T2, T3, T4, B1, B2, B3, B4;
  logic       win_valid, frame_done;
`ifdef ISP_WIN_COORD_EN
  logic [2:0] win_x;
  logic [1:0] win_y;
`endif

  always #5 clk = ~clk;

  pixel_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .win_valid(win_valid), .frame_done(frame_done)
`ifdef ISP_WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the frame as an image, windows read straight from it.
  logic [7:0] img [H][W];
  bit         m_act = 0;
  int         mr = 0, mc = 0;
  logic [7:0] exp_t [4];
  logic [7:0] exp_b [4];
  logic       exp_win, exp_done;
  int         exp_x = 0, exp_y = 0;

  int          nwin, ndone;
  logic [31:0] first_t, first_b, last_t, last_b;
  logic        last_done;
  int          first_x, first_y, last_x, last_y;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_accept(input logic v, input logic s, input logic [7:0] p);
    exp_win  = 1'b0;
    exp_done = 1'b0;
    if (v) begin
      if (s) begin
        m_act = 1; mr = 0; mc = 0;
      end
      if (m_act) begin
        img[mr][mc] = p;
        if (mr >= 1 && mc >= 3) begin
          exp_win = 1'b1;
          for (int k = 0; k < 4; k++) begin
            exp_t[k] = img[mr-1][mc-3+k];
            exp_b[k] = img[mr][mc-3+k];
          end
          exp_x = mc;
          exp_y = mr;
        end
        if (mr == H-1 && mc == W-1) begin
          exp_done = 1'b1;
          m_act    = 0;
        end
        if (mc == W-1) begin
          mc = 0; mr++;
        end else begin
          mc++;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] p);
    @(negedge clk);
    pix_valid = v; pix_sof = s; pix_in = p;
    model_accept(v, s, p);
    @(posedge clk);
    #1;
    chk("pix_ready", 64'(pix_ready), 64'd1);
    chk("win_valid", 64'(win_valid), 64'(exp_win));
    chk("frame_done", 64'(frame_done), 64'(exp_done));
    chk("T_window", 64'({T1, T2, T3, T4}), 64'({exp_t[0], exp_t[1], exp_t[2], exp_t[3]}));
    chk("B_window", 64'({B1, B2, B3, B4}), 64'({exp_b[0], exp_b[1], exp_b[2], exp_b[3]}));
`ifdef ISP_WIN_COORD_EN
    if (exp_win) begin
      chk("win_x", 64'(win_x), 64'(exp_x));
      chk("win_y", 64'(win_y), 64'(exp_y));
    end
`endif
    if (win_valid) begin
      nwin++;
      if (nwin == 1) begin
        first_t = {T1, T2, T3, T4};
        first_b = {B1, B2, B3, B4};
`ifdef ISP_WIN_COORD_EN
        first_x = int'(win_x); first_y = int'(win_y);
`endif
      end
      last_t    = {T1, T2, T3, T4};
      last_b    = {B1, B2, B3, B4};
      last_done = frame_done;
`ifdef ISP_WIN_COORD_EN
      last_x = int'(win_x); last_y = int'(win_y);
`endif
    end
    if (frame_done) ndone++;
  endtask

  task automatic send_frame(input int gapmax, input bit rnd, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r, c, ng;
      logic [7:0] val;
      r  = i / W;
      c  = i % W;
      ng = int'($urandom_range(gapmax));
      for (int g = 0; g < ng; g++) step(1'b0, 1'($urandom), 8'($urandom));
      val = rnd ? 8'($urandom) : 8'(8 * r + c);
      step(1'b1, (i == 0), val);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b1; pix_sof = 1'b0; pix_in = 8'hAA;
    #1 chk("ready_in_rst", 64'(pix_ready), 64'd0);
    m_act = 0;
    for (int k = 0; k < 4; k++) begin
      exp_t[k] = 8'h00; exp_b[k] = 8'h00;
    end
    @(posedge clk);
    #1;
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_T", 64'({T1, T2, T3, T4}), 64'd0);
    chk("rst_B", 64'({B1, B2, B3, B4}), 64'd0);
`ifdef ISP_WIN_COORD_EN
    chk("rst_win_x", 64'(win_x), 64'd0);
    chk("rst_win_y", 64'(win_y), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0; pix_valid = 1'b0;
    #1 chk("ready_after_rst", 64'(pix_ready), 64'd1);
  endtask

  task automatic clear_counts();
    nwin = 0; ndone = 0; last_done = 1'b0;
  endtask

  initial begin
    // Power-on reset
    do_reset();

    // Full frame, continuous valid
    clear_counts();
    send_frame(0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("s1_windows", 64'(nwin), 64'd15);
    chk("s1_done", 64'(ndone), 64'd1);
    chk("s1_first_T", 64'(first_t), 64'h00010203);
    chk("s1_first_B", 64'(first_b), 64'h08090a0b);
    chk("s1_last_T", 64'(last_t), 64'h14151617);
    chk("s1_last_B", 64'(last_b), 64'h1c1d1e1f);
    chk("s1_last_done", 64'(last_done), 64'd1);
`ifdef ISP_WIN_COORD_EN
    chk("s1_first_x", 64'(first_x), 64'd3);
    chk("s1_first_y", 64'(first_y), 64'd1);
    chk("s1_last_x", 64'(last_x), 64'd7);
    chk("s1_last_y", 64'(last_y), 64'd3);
`endif

    // Same frame with random gaps
    clear_counts();
    send_frame(3, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("s2_windows", 64'(nwin), 64'd15);
    chk("s2_last_T", 64'(last_t), 64'h14151617);
    chk("s2_last_B", 64'(last_b), 64'h1c1d1e1f);

    // Pre-frame junk then two back-to-back frames
    clear_counts();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    chk("s3_prefr_windows", 64'(nwin), 64'd0);
    send_frame(0, 0, W * H);
    send_frame(0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("s3_windows", 64'(nwin), 64'd30);
    chk("s3_done", 64'(ndone), 64'd2);

    // Abort with sof at pixel (2,5)
    clear_counts();
    send_frame(0, 0, 2 * W + 5);
    chk("s4_abort_done", 64'(ndone), 64'd0);
    clear_counts();
    send_frame(0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("s4_windows", 64'(nwin), 64'd15);
    chk("s4_done", 64'(ndone), 64'd1);

    // Reset at pixel (1,4)
    clear_counts();
    send_frame(0, 0, W + 4);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
    chk("s5_dropped_done", 64'(ndone), 64'd0);
    clear_counts();
    send_frame(0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("s5_windows", 64'(nwin), 64'd15);
    chk("s5_done", 64'(ndone), 64'd1);

    // Random pixel values with random gaps, two frames
    clear_counts();
    send_frame(3, 1, W * H);
    send_frame(2, 1, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("s6_windows", 64'(nwin), 64'd30);
    chk("s6_done", 64'(ndone), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
